// File: rtl/pmips_pkg.sv
// pmips_pkg: constants shared by the pMIPS fetch stage and control decoder.
//   - opcode constants (bits [15:13] of an instruction word)
//   - NOP_INSTR: bubble word. Its opcode decodes to all-zero controls.
//   - fetch_state_e: fetch-stage state encoding
package pmips_pkg;

    localparam logic [2:0] OP_R    = 3'd0;
    localparam logic [2:0] OP_NOP  = 3'd1;
    localparam logic [2:0] OP_BEQ  = 3'd2;
    localparam logic [2:0] OP_ADDI = 3'd3;
    localparam logic [2:0] OP_LW   = 3'd5;
    localparam logic [2:0] OP_SW   = 3'd6;

    // Opcode 0 is R-type and writes a register, so it is never a bubble.
    localparam logic [15:0] NOP_INSTR = {OP_NOP, 13'd0};

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FLUSH = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry buffer for a fetched word that returns while
// the pipeline is stalled.
//   i_clock, i_reset : clock, synchronous active-high reset (empties buffer)
//   i_load           : capture i_instr / i_pc1 and mark valid
//   i_clear          : empty the buffer (wins over i_load)
//   o_valid, o_instr, o_pc1 : buffered entry
module fetch_skid #(
    parameter int PC_W = 8
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_load,
    input  logic            i_clear,
    input  logic [15:0]     i_instr,
    input  logic [PC_W-1:0] i_pc1,
    output logic            o_valid,
    output logic [15:0]     o_instr,
    output logic [PC_W-1:0] o_pc1
);

    logic            r_valid;
    logic [15:0]     r_instr;
    logic [PC_W-1:0] r_pc1;

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end
    end

    // Payload needs no reset: it is only consumed while r_valid is set.
    always_ff @(posedge i_clock) begin
        if (i_load) begin
            r_instr <= i_instr;
            r_pc1   <= i_pc1;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc1   = r_pc1;

endmodule

// File: rtl/fetch_issue.sv
// fetch_issue: instruction-fetch stage of the 16-bit pMIPS pipeline.
// Owns the PC, runs the imem request/ready handshake and loads IF/ID.
// The decoder only ever sees real instructions or the NOP bubble.
//   clock, reset               : clock, synchronous active-high reset
//   imem_addr/req/ready/data   : instruction memory port (addr == pc)
//   stall                      : hold IF/ID and pc
//   branch_taken/branch_target : redirect (priority over stall)
//   if_id_instr/opcode/pc1/valid : IF/ID register outputs
module fetch_issue #(
    parameter int              PC_W      = 8,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [15:0]     NOP_INSTR = pmips_pkg::NOP_INSTR
) (
    input  logic            clock,
    input  logic            reset,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_req,
    input  logic            imem_ready,
    input  logic [15:0]     imem_data,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic [15:0]     if_id_instr,
    output logic [2:0]      if_id_opcode,
    output logic [PC_W-1:0] if_id_pc1,
    output logic            if_id_valid
);

    import pmips_pkg::*;

    fetch_state_e    r_state;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_if_id_instr;
    logic [PC_W-1:0] r_if_id_pc1;
    logic            r_if_id_valid;

    logic [PC_W-1:0] w_pc_inc;
    logic            w_req;
    logic            w_outstanding;
    logic            w_skid_load;
    logic            w_skid_clear;
    logic            w_skid_valid;
    logic [15:0]     w_skid_instr;
    logic [PC_W-1:0] w_skid_pc1;

    assign w_pc_inc = r_pc + 1'b1;   // wraps modulo 2^PC_W
    assign w_req    = (r_state == ST_FETCH);

    // A word is still owed by memory if we asked and it has not answered.
    // A second redirect while already flushing keeps waiting for that word,
    // otherwise it would be taken as the target's instruction.
    assign w_outstanding = (w_req || (r_state == ST_FLUSH)) && !imem_ready;

    assign w_skid_load  = (r_state == ST_FETCH) && stall && imem_ready;
    assign w_skid_clear = branch_taken || ((r_state == ST_HOLD) && !stall);

    fetch_skid #(.PC_W(PC_W)) u_skid (
        .i_clock (clock),
        .i_reset (reset),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_instr (imem_data),
        .i_pc1   (w_pc_inc),
        .o_valid (w_skid_valid),
        .o_instr (w_skid_instr),
        .o_pc1   (w_skid_pc1)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_PC;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_pc1   <= '0;
            r_if_id_valid <= 1'b0;
        end else if (branch_taken) begin
            // Squash whatever is in flight; the target is fetched next.
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
            r_pc          <= branch_target;
            r_state       <= w_outstanding ? ST_FLUSH : ST_FETCH;
        end else begin
            case (r_state)
                ST_BOOT: r_state <= ST_FETCH;
                ST_FETCH: begin
                    if (imem_ready) begin
                        r_pc <= w_pc_inc;
                        if (stall) begin
                            r_state <= ST_HOLD;   // word parked in skid buffer
                        end else begin
                            r_if_id_instr <= imem_data;
                            r_if_id_pc1   <= w_pc_inc;
                            r_if_id_valid <= 1'b1;
                        end
                    end else if (!stall) begin
                        r_if_id_instr <= NOP_INSTR;
                        r_if_id_valid <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    // Release edge loads IF/ID directly, no memory cycle lost.
                    if (!stall) begin
                        r_if_id_instr <= w_skid_instr;
                        r_if_id_pc1   <= w_skid_pc1;
                        r_if_id_valid <= w_skid_valid;
                        r_state       <= ST_FETCH;
                    end
                end
                ST_FLUSH: begin
                    // The late wrong-path word is dropped here.
                    if (imem_ready) r_state <= ST_FETCH;
                end
                default: r_state <= ST_BOOT;
            endcase
        end
    end

    assign imem_addr    = r_pc;
    assign imem_req     = w_req;
    assign if_id_instr  = r_if_id_instr;
    assign if_id_opcode = r_if_id_instr[15:13];
    assign if_id_pc1    = r_if_id_pc1;
    assign if_id_valid  = r_if_id_valid;

endmodule

// File: tb/tb_fetch_issue.sv
module tb_fetch_issue;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  imem_addr;
    logic        imem_req;
    logic        imem_ready = 1'b0;
    logic [15:0] imem_data = 16'h0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [7:0]  branch_target = 8'h0;
    logic [15:0] if_id_instr;
    logic [2:0]  if_id_opcode;
    logic [7:0]  if_id_pc1;
    logic        if_id_valid;

    always #5 clock = ~clock;

    fetch_issue #(.PC_W(8), .RESET_PC(8'h00), .NOP_INSTR(16'h2000)) dut (
        .clock         (clock),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_req      (imem_req),
        .imem_ready    (imem_ready),
        .imem_data     (imem_data),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_id_instr   (if_id_instr),
        .if_id_opcode  (if_id_opcode),
        .if_id_pc1     (if_id_pc1),
        .if_id_valid   (if_id_valid)
    );

    localparam logic [15:0] NOP = 16'h2000;

    logic [15:0] rom [256];
    int n_pass  = 0;
    int n_total = 0;

    // memory model: one request at a time, fixed or random latency
    bit         m_pend = 0;
    logic [7:0] m_addr;
    int         m_wait;
    int         mem_lat = 0;   // <0 : random 0..2

    // reference model: program-order stream of expected fetch addresses
    logic [7:0]  exp_addr = 8'h00;
    logic        s_r, s_b, s_s;
    logic [7:0]  s_t;
    logic [15:0] p_instr;
    logic [7:0]  p_pc1;
    logic        p_valid;
    int          starve = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    task automatic model_check();
        logic [7:0] nx;
        chk("mdl_opcode", {29'd0, if_id_opcode}, {29'd0, if_id_instr[15:13]});
        if (s_r) begin
            chk("mdl_rst_instr", {16'd0, if_id_instr}, {16'd0, NOP});
            chk("mdl_rst_valid", {31'd0, if_id_valid}, 0);
            chk("mdl_rst_pc1", {24'd0, if_id_pc1}, 0);
            chk("mdl_rst_addr", {24'd0, imem_addr}, 0);
            chk("mdl_rst_req", {31'd0, imem_req}, 0);
            exp_addr = 8'h00;
            starve = 0;
        end else if (s_b) begin
            chk("mdl_br_valid", {31'd0, if_id_valid}, 0);
            chk("mdl_br_instr", {16'd0, if_id_instr}, {16'd0, NOP});
            chk("mdl_br_addr", {24'd0, imem_addr}, {24'd0, s_t});
            exp_addr = s_t;
        end else if (s_s) begin
            chk("mdl_stall_instr", {16'd0, if_id_instr}, {16'd0, p_instr});
            chk("mdl_stall_valid", {31'd0, if_id_valid}, {31'd0, p_valid});
            chk("mdl_stall_pc1", {24'd0, if_id_pc1}, {24'd0, p_pc1});
        end else if (if_id_valid === 1'b1) begin
            nx = exp_addr + 8'd1;
            chk("mdl_instr", {16'd0, if_id_instr}, {16'd0, rom[exp_addr]});
            chk("mdl_pc1", {24'd0, if_id_pc1}, {24'd0, nx});
            exp_addr = nx;
            starve = 0;
        end else begin
            chk("mdl_bubble", {16'd0, if_id_instr}, {16'd0, NOP});
        end
        if (!s_r && !(if_id_valid === 1'b1)) starve++;
        if (starve > 60) begin
            n_total++;
            $display("FAIL progress: %0d cycles without a new instruction, limit 60", starve);
            starve = 0;
        end
    endtask

    // Called just after a falling edge with the inputs already set.
    task automatic step();
        if (reset) begin
            m_pend = 0;
            imem_ready = 1'b0;
        end else begin
            if (!m_pend && imem_req) begin
                m_pend = 1;
                m_addr = imem_addr;
                m_wait = (mem_lat < 0) ? int'($urandom_range(2, 0)) : mem_lat;
            end
            if (m_pend && m_wait == 0) begin
                imem_ready = 1'b1;
                imem_data  = rom[m_addr];
                m_pend     = 0;
            end else begin
                imem_ready = 1'b0;
                imem_data  = 16'($urandom);
                if (m_pend) m_wait--;
            end
        end
        s_r = reset; s_b = branch_taken; s_s = stall; s_t = branch_target;
        p_instr = if_id_instr; p_pc1 = if_id_pc1; p_valid = if_id_valid;
        @(posedge clock);
        #1;
        model_check();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    typedef struct {
        logic        st;
        logic        br;
        logic [7:0]  tgt;
        logic        ev;
        logic [15:0] ei;
        logic [7:0]  ep;
        logic [7:0]  ea;
        logic        er;
    } vec_t;

    vec_t tv [16];

    initial begin
        bit got;
        for (int i = 0; i < 256; i++) rom[i] = {8'(i * 37 + 11), 8'(i)};
        rom[0] = 16'h0123; rom[1] = 16'h6004; rom[2] = 16'hA005; rom[3] = 16'hC006;

        // zero-wait fetch, 3-cycle stall, branch, stall+branch with skid full
        tv[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, NOP,      8'h00, 8'h00, 1'b1};
        tv[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 16'h0123, 8'h01, 8'h01, 1'b1};
        tv[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 16'h6004, 8'h02, 8'h02, 1'b1};
        tv[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 16'hA005, 8'h03, 8'h03, 1'b1};
        tv[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 16'hC006, 8'h04, 8'h04, 1'b1};
        tv[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 16'hC006, 8'h04, 8'h05, 1'b0};
        tv[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 16'hC006, 8'h04, 8'h05, 1'b0};
        tv[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 16'hC006, 8'h04, 8'h05, 1'b0};
        tv[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, rom[4],   8'h05, 8'h05, 1'b1};
        tv[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, rom[5],   8'h06, 8'h06, 1'b1};
        tv[10] = '{1'b0, 1'b1, 8'h40, 1'b0, NOP,      8'h00, 8'h40, 1'b1};
        tv[11] = '{1'b0, 1'b0, 8'h00, 1'b1, rom[8'h40], 8'h41, 8'h41, 1'b1};
        tv[12] = '{1'b0, 1'b0, 8'h00, 1'b1, rom[8'h41], 8'h42, 8'h42, 1'b1};
        tv[13] = '{1'b1, 1'b0, 8'h00, 1'b1, rom[8'h41], 8'h42, 8'h43, 1'b0};
        tv[14] = '{1'b1, 1'b1, 8'h80, 1'b0, NOP,      8'h00, 8'h80, 1'b1};
        tv[15] = '{1'b0, 1'b0, 8'h00, 1'b1, rom[8'h80], 8'h81, 8'h81, 1'b1};

        @(negedge clock);
        mem_lat = 0;
        do_reset();
        chk("rst_instr", {16'd0, if_id_instr}, {16'd0, NOP});
        chk("rst_opcode", {29'd0, if_id_opcode}, 1);
        chk("rst_valid", {31'd0, if_id_valid}, 0);
        chk("rst_req", {31'd0, imem_req}, 0);

        for (int k = 0; k < 16; k++) begin
            stall = tv[k].st; branch_taken = tv[k].br; branch_target = tv[k].tgt;
            step();
            chk($sformatf("tv%0d_valid", k), {31'd0, if_id_valid}, {31'd0, tv[k].ev});
            chk($sformatf("tv%0d_instr", k), {16'd0, if_id_instr}, {16'd0, tv[k].ei});
            chk($sformatf("tv%0d_opcode", k), {29'd0, if_id_opcode}, {29'd0, tv[k].ei[15:13]});
            if (tv[k].ev) chk($sformatf("tv%0d_pc1", k), {24'd0, if_id_pc1}, {24'd0, tv[k].ep});
            chk($sformatf("tv%0d_addr", k), {24'd0, imem_addr}, {24'd0, tv[k].ea});
            chk($sformatf("tv%0d_req", k), {31'd0, imem_req}, {31'd0, tv[k].er});
        end
        stall = 1'b0; branch_taken = 1'b0;

        // branch while a 2-cycle memory wait is outstanding
        mem_lat = 2;
        do_reset();
        step();
        step();
        chk("wait_bubble", {31'd0, if_id_valid}, 0);
        branch_taken = 1'b1; branch_target = 8'h20;
        step();
        branch_taken = 1'b0;
        chk("flush_req", {31'd0, imem_req}, 0);
        chk("flush_addr", {24'd0, imem_addr}, 32'h20);
        step();   // late word returns here and must be dropped
        chk("flush_drop_instr", {16'd0, if_id_instr}, {16'd0, NOP});
        chk("flush_drop_valid", {31'd0, if_id_valid}, 0);
        got = 0;
        for (int c = 0; c < 12 && !got; c++) begin
            step();
            if (if_id_valid === 1'b1) got = 1;
        end
        if (got) begin
            chk("flush_target_instr", {16'd0, if_id_instr}, {16'd0, rom[8'h20]});
            chk("flush_target_pc1", {24'd0, if_id_pc1}, 32'h21);
        end else begin
            n_total++;
            $display("FAIL flush_target: no valid instruction within 12 cycles, expected %0h", rom[8'h20]);
        end

        // pc wrap at 0xFF
        mem_lat = 0;
        branch_taken = 1'b1; branch_target = 8'hFF;
        step();
        branch_taken = 1'b0;
        chk("wrap_addr", {24'd0, imem_addr}, 32'hFF);
        step();
        chk("wrap_instr", {16'd0, if_id_instr}, {16'd0, rom[8'hFF]});
        chk("wrap_pc1", {24'd0, if_id_pc1}, 0);
        chk("wrap_next_addr", {24'd0, imem_addr}, 0);
        step();
        chk("wrap_after_instr", {16'd0, if_id_instr}, {16'd0, rom[0]});
        chk("wrap_after_pc1", {24'd0, if_id_pc1}, 1);

        // reset asserted in the middle of a memory wait
        mem_lat = 2;
        step();
        step();
        reset = 1'b1;
        step();
        chk("midrst_instr", {16'd0, if_id_instr}, {16'd0, NOP});
        chk("midrst_opcode", {29'd0, if_id_opcode}, 1);
        chk("midrst_pc1", {24'd0, if_id_pc1}, 0);
        chk("midrst_valid", {31'd0, if_id_valid}, 0);
        chk("midrst_addr", {24'd0, imem_addr}, 0);
        chk("midrst_req", {31'd0, imem_req}, 0);
        reset = 1'b0;

        // random traffic against the stream model
        mem_lat = -1;
        for (int n = 0; n < 2500; n++) begin
            reset         = ($urandom_range(199, 0) == 0);
            stall         = ($urandom_range(3, 0) == 0);
            branch_taken  = ($urandom_range(15, 0) == 0);
            branch_target = 8'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
